// File: rtl/regfile_write_arbiter_pkg.sv
// Shared helpers for the register-file write arbiter.
//   clog2_min1    : index width for a count, never below 1 bit
//   onehot_decode : register address -> per-register enable, zero when out of range
package svlib_regfile_pkg;

  // Widest register bank the decode helper can address
  localparam int unsigned MAX_REGS   = 256;
  localparam int unsigned MAX_ADDR_W = 8;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_REGS-1:0] onehot_decode(input int unsigned addr,
                                                        input int unsigned num_regs);
    logic [MAX_REGS-1:0] res;
    res = '0;
    if (addr < num_regs && addr < MAX_REGS) begin
      res[addr[MAX_ADDR_W-1:0]] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter holding its own priority pointer.
//   clk, rstn   : clock, async active-low reset
//   i_req       : request vector
//   i_en        : grants allowed this cycle
//   i_advance   : the current grant was taken; move pointer past the winner
//   o_gnt       : one-hot grant, all zero when disabled or nothing requested
//   o_gnt_idx   : binary index of the winner (0 when no grant)
module rr_arbiter
  import svlib_regfile_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;
  int unsigned        w_cand_int;

  // Scan from the pointer upward, wrapping; the first requester seen wins
  always_comb begin
    w_gnt      = '0;
    w_gnt_idx  = '0;
    w_found    = 1'b0;
    w_cand_int = 0;
    w_cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand_int = (32'(r_ptr) + k) % NUM_REQ;
      w_cand     = IDX_W'(w_cand_int);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        w_gnt[w_cand]    = 1'b1;
        w_gnt_idx        = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_gnt_idx;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single write port of a register bank among NUM_REQ requesters.
// Round-robin arbitration, one-hot decode of the winning address, one-cycle issue stage.
//   clk, rstn    : clock, async active-low reset
//   i_req_valid  : per-requester write request
//   i_req_addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_req_data   : packed data, requester i at [i*WIDTH +: WIDTH]
//   o_req_ready  : one-hot accept; transfer on valid & ready
//   i_stall      : blocks all grants while high
//   o_wr_en      : registered one-hot per-register enable
//   o_wr_data    : registered write data
//   o_wr_src     : registered index of the issuing requester
//   o_addr_err   : sticky, an out-of-range address was accepted
//   o_wr_count   : saturating count of issued in-range writes
module regfile_write_arbiter
  import svlib_regfile_pkg::*;
#(
  parameter int unsigned  NUM_REQ  = 4,
  parameter int unsigned  NUM_REGS = 8,
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  CNT_W    = 16,
  localparam int unsigned ADDR_W   = clog2_min1(NUM_REGS),
  localparam int unsigned SRC_W    = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_stall,
  output logic [NUM_REGS-1:0]       o_wr_en,
  output logic [WIDTH-1:0]          o_wr_data,
  output logic [SRC_W-1:0]          o_wr_src,
  output logic                      o_addr_err,
  output logic [CNT_W-1:0]          o_wr_count
);

  logic [NUM_REQ-1:0]  w_gnt;
  logic [SRC_W-1:0]    w_gnt_idx;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_in_range;
  logic [NUM_REGS-1:0] w_dec;

  logic [NUM_REGS-1:0] r_wr_en;
  logic [WIDTH-1:0]    r_wr_data;
  logic [SRC_W-1:0]    r_wr_src;
  logic                r_addr_err;
  logic [CNT_W-1:0]    r_wr_count;

  // Gating with rstn keeps req_ready low for the whole time reset is held
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (i_req_valid),
    .i_en      (~i_stall & rstn),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_xfer     = |w_gnt;
  assign w_sel_addr = i_req_addr[32'(w_gnt_idx) * ADDR_W +: ADDR_W];
  assign w_sel_data = i_req_data[32'(w_gnt_idx) * WIDTH +: WIDTH];
  assign w_in_range = (32'(w_sel_addr) < NUM_REGS);
  assign w_dec      = NUM_REGS'(onehot_decode(32'(w_sel_addr), NUM_REGS));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_en    <= '0;
      r_wr_data  <= '0;
      r_wr_src   <= '0;
      r_addr_err <= 1'b0;
      r_wr_count <= '0;
    end else begin
      // Decode is already zero for an out-of-range address
      r_wr_en <= w_xfer ? w_dec : '0;
      if (w_xfer) begin
        r_wr_data <= w_sel_data;
        r_wr_src  <= w_gnt_idx;
        if (!w_in_range) begin
          r_addr_err <= 1'b1;
        end else if (r_wr_count != {CNT_W{1'b1}}) begin
          r_wr_count <= r_wr_count + 1'b1;
        end
      end
    end
  end

  assign o_req_ready = w_gnt;
  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;
  assign o_wr_src    = r_wr_src;
  assign o_addr_err  = r_addr_err;
  assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: 4 requesters, 6 registers, 4-bit counter.
module tb_regfile_write_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned SRC_W    = 2;

  logic                      clk;
  logic                      rstn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      stall;
  logic [NUM_REGS-1:0]       wr_en;
  logic [WIDTH-1:0]          wr_data;
  logic [SRC_W-1:0]          wr_src;
  logic                      addr_err;
  logic [CNT_W-1:0]          wr_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_stall     (stall),
    .o_wr_en     (wr_en),
    .o_wr_data   (wr_data),
    .o_wr_src    (wr_src),
    .o_addr_err  (addr_err),
    .o_wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] data_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h11;
  endfunction

  initial begin
    int exp_cnt;
    rstn      = 1'b0;
    stall     = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = 3'(i);
      req_data[i*WIDTH +: WIDTH]   = data_of(i);
    end
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_count", 32'(wr_count), 32'h0);
    check("rst_err", 32'(addr_err), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);

    // Strict rotation with all requesters valid
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << k));
      tick();
      check($sformatf("rr_wr_en%0d", k), 32'(wr_en), 32'(1 << k));
      check($sformatf("rr_src%0d", k), 32'(wr_src), 32'(k));
      check($sformatf("rr_data%0d", k), wr_data, data_of(k));
    end
    check("rr_count", 32'(wr_count), 32'd4);
    check("rr_wrap", 32'(req_ready), 32'h1);

    // Stall for 3 cycles, rotation resumes at the saved pointer
    stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      check($sformatf("stall_wr_en%0d", k), 32'(wr_en), 32'h0);
    end
    stall = 1'b0;
    #1;
    check("stall_resume", 32'(req_ready), 32'h1);
    check("stall_count", 32'(wr_count), 32'd4);

    // Out-of-range write from requester 2
    req_valid = 4'b0100;
    req_addr[2*ADDR_W +: ADDR_W] = 3'd7;
    #1;
    check("oor_ready", 32'(req_ready), 32'h4);
    tick();
    check("oor_wr_en", 32'(wr_en), 32'h0);
    check("oor_err", 32'(addr_err), 32'h1);
    check("oor_count", 32'(wr_count), 32'd4);
    check("oor_src", 32'(wr_src), 32'd2);
    req_valid = 4'hF;
    req_addr[2*ADDR_W +: ADDR_W] = 3'd2;
    #1;
    check("oor_next", 32'(req_ready), 32'h8);
    tick();
    check("oor_next_wr_en", 32'(wr_en), 32'h8);
    check("oor_next_count", 32'(wr_count), 32'd5);
    check("err_sticky", 32'(addr_err), 32'h1);

    // Single requester wins every cycle; counter saturates at 15
    req_valid = 4'b0001;
    exp_cnt   = 5;
    #1;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("sat_ready%0d", k), 32'(req_ready), 32'h1);
      tick();
      if (exp_cnt < 15) exp_cnt++;
      check($sformatf("sat_wr_en%0d", k), 32'(wr_en), 32'h1);
      check($sformatf("sat_count%0d", k), 32'(wr_count), 32'(exp_cnt));
    end
    check("sat_final", 32'(wr_count), 32'd15);
    req_valid = 4'b0000;
    tick();
    check("idle_wr_en", 32'(wr_en), 32'h0);

    // Reset while a write to register 4 is presented
    req_valid = 4'hF;
    req_addr[1*ADDR_W +: ADDR_W] = 3'd4;
    #1;
    check("mid_ready", 32'(req_ready), 32'h2);
    tick();
    check("mid_wr_en", 32'(wr_en), 32'h10);
    rstn = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_count", 32'(wr_count), 32'h0);
    check("mid_rst_err", 32'(addr_err), 32'h0);
    tick();
    check("mid_rst_hold", 32'(wr_en), 32'h0);
    rstn = 1'b1;
    req_addr[1*ADDR_W +: ADDR_W] = 3'd1;
    #1;
    check("mid_ptr0", 32'(req_ready), 32'h1);
    tick();
    check("mid_after_wr_en", 32'(wr_en), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
